// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Provides the operand-forwarding select encodings, the controller FSM state
// encodings, the register-index width and a helper that computes one forward select.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN     = 2'd0;
  localparam state_t ST_WAIT    = 2'd1;
  localparam state_t ST_ERR_REL = 2'd2;

  // Youngest producer wins. A load in EX has no data yet, so it is skipped here.
  // The load-use stall covers that case.
  function automatic logic [1:0] fwd_sel(
    input logic             use_src,
    input logic [REG_W-1:0] src,
    input logic             regwr_ex,
    input logic             memrd_ex,
    input logic [REG_W-1:0] rd_ex,
    input logic             regwr_mem,
    input logic [REG_W-1:0] rd_mem,
    input logic             regwr_wb,
    input logic [REG_W-1:0] rd_wb
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src && (src != '0)) begin
      if (regwr_ex && !memrd_ex && (rd_ex == src))  sel = FWD_EX;
      else if (regwr_mem && (rd_mem == src))        sel = FWD_MEM;
      else if (regwr_wb && (rd_wb == src))          sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_sat_counter.sv
// Saturating up-counter used for the hazard event statistics.
// Ports: clk, rst (sync, active-high), inc_i (count enable), cnt_o (count value).
// The count holds at all-ones and does not wrap.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                          cnt_q <= '0;
    else if (inc_i && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline.
// Inputs:  ID register-use fields (rs_id/rt_id/use_*), take_id, the EX/MEM/WB
//          destination/control fields, and mem_ready from the data memory.
// Outputs: PC/IF-ID/ID-EX controls (pc_en, disable_IR, kill, stall, freeze),
//          ID forwarding selects fwdA/fwdB, sticky mem_err, and event counters.
//
//  state   | meaning
//  RUN     | normal flow; a memory wait moves to WAIT
//  WAIT    | MEM access outstanding, watchdog counting
//  ERR_REL | watchdog expired; access forced complete for one cycle
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             take_id,
  input  logic             RegWr_EX,
  input  logic             MemRd_EX,
  input  logic [REG_W-1:0] Rd_EX,
  input  logic             RegWr_MEM,
  input  logic             MemRd_MEM,
  input  logic             MemWr_MEM,
  input  logic [REG_W-1:0] Rd_MEM,
  input  logic             RegWr_WB,
  input  logic [REG_W-1:0] Rd_WB,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             disable_IR,
  output logic             kill,
  output logic             stall,
  output logic             freeze,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] kill_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            lu, mw;

  assign fwdA = fwd_sel(use_rs_id, rs_id, RegWr_EX, MemRd_EX, Rd_EX,
                        RegWr_MEM, Rd_MEM, RegWr_WB, Rd_WB);
  assign fwdB = fwd_sel(use_rt_id, rt_id, RegWr_EX, MemRd_EX, Rd_EX,
                        RegWr_MEM, Rd_MEM, RegWr_WB, Rd_WB);

  assign lu = MemRd_EX && RegWr_EX && (Rd_EX != '0) &&
              ((use_rs_id && (Rd_EX == rs_id)) || (use_rt_id && (Rd_EX == rt_id)));

  // In ERR_REL the stuck access is treated as done, so it cannot freeze again.
  assign mw = (MemRd_MEM || MemWr_MEM) && !mem_ready && (state_q != ST_ERR_REL);

  // A branch under a stall is not squashed yet. The ID instruction is held,
  // so take_id is still present when the stall releases and kills then.
  always_comb begin
    pc_en      = 1'b1;
    disable_IR = 1'b0;
    kill       = 1'b0;
    stall      = 1'b0;
    freeze     = 1'b0;
    if (mw) begin
      freeze     = 1'b1;
      pc_en      = 1'b0;
      disable_IR = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      disable_IR = 1'b1;
      stall      = 1'b1;
    end else if (take_id) begin
      kill = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (mw) begin
          state_d = ST_WAIT;
          wd_d    = WD_ONE;
        end
      end
      ST_WAIT: begin
        if (!mw) begin
          state_d = ST_RUN;
          wd_d    = '0;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_ERR_REL;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_ERR_REL: begin
        state_d = ST_RUN;
        wd_d    = '0;
      end
      default: begin
        state_d = ST_RUN;
        wd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign mem_err = err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc_i(stall), .cnt_o(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_kill_cnt (
    .clk(clk), .rst(rst), .inc_i(kill), .cnt_o(kill_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk(clk), .rst(rst), .inc_i(freeze), .cnt_o(wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 2;
  localparam int MEM_TIMEOUT = 4;

  logic             clk, rst;
  logic [4:0]       rs_id, rt_id, Rd_EX, Rd_MEM, Rd_WB;
  logic             use_rs_id, use_rt_id, take_id;
  logic             RegWr_EX, MemRd_EX, RegWr_MEM, MemRd_MEM, MemWr_MEM, RegWr_WB;
  logic             mem_ready;
  logic             pc_en, disable_IR, kill, stall, freeze, mem_err;
  logic [1:0]       fwdA, fwdB;
  logic [CNT_W-1:0] stall_cnt, kill_cnt, wait_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .take_id(take_id),
    .RegWr_EX(RegWr_EX), .MemRd_EX(MemRd_EX), .Rd_EX(Rd_EX),
    .RegWr_MEM(RegWr_MEM), .MemRd_MEM(MemRd_MEM), .MemWr_MEM(MemWr_MEM), .Rd_MEM(Rd_MEM),
    .RegWr_WB(RegWr_WB), .Rd_WB(Rd_WB), .mem_ready(mem_ready),
    .pc_en(pc_en), .disable_IR(disable_IR), .kill(kill), .stall(stall), .freeze(freeze),
    .fwdA(fwdA), .fwdB(fwdB), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .kill_cnt(kill_cnt), .wait_cnt(wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0; take_id = 0;
    RegWr_EX = 0; MemRd_EX = 0; Rd_EX = 0;
    RegWr_MEM = 0; MemRd_MEM = 0; MemWr_MEM = 0; Rd_MEM = 0;
    RegWr_WB = 0; Rd_WB = 0; mem_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic ctl(input string tag, input logic pc, input logic dis, input logic kl,
                     input logic st, input logic fz);
    check({tag, ".pc_en"},      {31'd0, pc_en},      {31'd0, pc});
    check({tag, ".disable_IR"}, {31'd0, disable_IR}, {31'd0, dis});
    check({tag, ".kill"},       {31'd0, kill},       {31'd0, kl});
    check({tag, ".stall"},      {31'd0, stall},      {31'd0, st});
    check({tag, ".freeze"},     {31'd0, freeze},     {31'd0, fz});
  endtask

  initial begin
    rst = 1;
    do_reset();

    // reset state
    #1;
    ctl("rst", 1, 0, 0, 0, 0);
    check("rst.fwdA", fwdA, 0);
    check("rst.mem_err", mem_err, 0);
    check("rst.stall_cnt", stall_cnt, 0);
    check("rst.kill_cnt", kill_cnt, 0);
    check("rst.wait_cnt", wait_cnt, 0);

    // load-use, then forwarding from MEM once the load moves on
    tick();
    RegWr_EX = 1; MemRd_EX = 1; Rd_EX = 5; rs_id = 5; use_rs_id = 1;
    #1;
    ctl("lu", 0, 1, 0, 1, 0);
    tick();
    check("lu.stall_cnt", stall_cnt, 1);
    RegWr_EX = 0; MemRd_EX = 0; Rd_EX = 0;
    RegWr_MEM = 1; MemRd_MEM = 1; Rd_MEM = 5;
    #1;
    check("lu_next.fwdA", fwdA, 2);
    ctl("lu_next", 1, 0, 0, 0, 0);
    use_rs_id = 0;
    #1;
    check("lu_next.fwdA_unused", fwdA, 0);
    tick();
    check("lu_next.stall_cnt", stall_cnt, 1);

    // forward priority on rt
    idle();
    RegWr_EX = 1; Rd_EX = 3; RegWr_MEM = 1; Rd_MEM = 3; RegWr_WB = 1; Rd_WB = 3;
    rt_id = 3; use_rt_id = 1;
    #1;
    check("fwd.ex", fwdB, 1);
    RegWr_EX = 0;
    #1;
    check("fwd.mem", fwdB, 2);
    RegWr_MEM = 0;
    #1;
    check("fwd.wb", fwdB, 3);
    RegWr_EX = 1; MemRd_EX = 1; RegWr_MEM = 1;
    #1;
    check("fwd.ld_ex_mem", fwdB, 2);
    check("fwd.ld_ex_stall", {31'd0, stall}, 1);
    MemRd_EX = 0;
    rt_id = 0;
    #1;
    check("fwd.rt0", fwdB, 0);
    Rd_EX = 0; Rd_MEM = 0; Rd_WB = 0;
    #1;
    check("fwd.r0", fwdB, 0);
    check("fwd.r0_stall", {31'd0, stall}, 0);
    tick();

    // branch squash, and branch coinciding with load-use
    idle();
    take_id = 1;
    #1;
    ctl("br", 1, 0, 1, 0, 0);
    tick();
    check("br.kill_cnt", kill_cnt, 1);
    take_id = 0;
    RegWr_EX = 1; MemRd_EX = 1; Rd_EX = 7; rt_id = 7; use_rt_id = 1; take_id = 1;
    #1;
    ctl("br_lu", 0, 1, 0, 1, 0);
    tick();
    check("br_lu.kill_cnt", kill_cnt, 1);
    RegWr_EX = 0; MemRd_EX = 0; Rd_EX = 0;
    #1;
    ctl("br_rel", 1, 0, 1, 0, 0);
    tick();
    check("br_rel.kill_cnt", kill_cnt, 2);
    check("br_rel.stall_cnt", stall_cnt, 2);

    // memory wait of three cycles
    do_reset();
    MemRd_MEM = 1; RegWr_MEM = 1; Rd_MEM = 9; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      ctl($sformatf("mw%0d", i), 0, 1, 0, 0, 1);
      tick();
    end
    mem_ready = 1;
    #1;
    ctl("mw_done", 1, 0, 0, 0, 0);
    tick();
    check("mw.wait_cnt", wait_cnt, 3);
    check("mw.mem_err", mem_err, 0);

    // watchdog expiry
    do_reset();
    MemRd_MEM = 1; mem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      check($sformatf("wd_frz%0d", i), {31'd0, freeze}, 1);
      check($sformatf("wd_err%0d", i), {31'd0, mem_err}, 0);
      tick();
    end
    #1;
    ctl("wd_rel", 1, 0, 0, 0, 0);
    check("wd_rel.mem_err", mem_err, 1);
    check("wd_rel.wait_cnt", wait_cnt, 3);
    tick();
    MemRd_MEM = 0; mem_ready = 1;
    tick();
    tick();
    check("wd_sticky.mem_err", mem_err, 1);
    check("wd_sticky.freeze", {31'd0, freeze}, 0);

    // counter saturation
    do_reset();
    check("sat.mem_err_cleared", mem_err, 0);
    RegWr_EX = 1; MemRd_EX = 1; Rd_EX = 4; rs_id = 4; use_rs_id = 1;
    tick();
    tick();
    check("sat.stall_cnt2", stall_cnt, 2);
    tick();
    tick();
    tick();
    check("sat.stall_cnt5", stall_cnt, 3);

    // reset in the middle of WAIT
    idle();
    MemRd_MEM = 1; mem_ready = 0;
    tick();
    tick();
    check("rstw.wait_cnt", wait_cnt, 2);
    rst = 1;
    tick();
    rst = 0;
    idle();
    check("rstw.stall_cnt", stall_cnt, 0);
    check("rstw.wait_cnt", wait_cnt, 0);
    check("rstw.kill_cnt", kill_cnt, 0);
    check("rstw.mem_err", mem_err, 0);
    // full watchdog window again proves the watchdog restarted from zero
    MemRd_MEM = 1; mem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      check($sformatf("rstw_frz%0d", i), {31'd0, freeze}, 1);
      tick();
    end
    #1;
    check("rstw_rel.freeze", {31'd0, freeze}, 0);
    check("rstw_rel.mem_err", mem_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
